noc_depacketizer: RTL and testbench

NOC_DEPACKETIZER -- requirements
Module: noc_depacketizer

---
 rtl/noc_depacketizer.sv | 174 +++++++++++++++++
 tb/tb_noc_depacketizer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_depacketizer.sv
// noc_depacketizer
//   Strips NoC framing from a packet stream addressed to this node. A header
//   flit opens the packet and carries the source/destination IDs, body flits
//   carry payload, and a tail flit closes the packet. Body payload is delayed
//   through a one-entry hold register so the last body flit can be flagged
//   with out_last when the tail arrives.
//
//   Optional feature: define NOC_DEPKT_STATS_EN to build the saturating
//   good-packet and error counters; otherwise pkt_cnt/err_cnt read 0.
//
// Ports
//   noc_clk, noc_rst        clock, synchronous active-high reset
//   in_valid/in_ready       flit handshake from router
//   in_flit                 {is_header, is_tail, data[DATA_W-1:0]}
//   out_valid/out_ready     payload handshake to consumer
//   out_data, out_last      body payload, last-body-flit flag
//   out_src_x, out_src_y    source ID of the packet being delivered
//   pkt_done                pulse: packet completed cleanly
//   err_misroute, err_proto pulses: destination mismatch, framing violation
//   pkt_cnt, err_cnt        saturating statistics counters
//
// state | meaning
// IDLE  | waiting for a header flit
// BODY  | accepted packet in progress, forwarding body flits
// DROP  | discarding a rejected packet until its tail
module noc_depacketizer #(
  parameter int          DATA_W    = 64,
  parameter int          X_W       = 4,
  parameter int          Y_W       = 4,
  parameter int          MY_X      = 0,
  parameter int          MY_Y      = 0,
  parameter logic [7:0]  HEAD_MARK = 8'hA5,
  parameter logic [7:0]  TAIL_MARK = 8'h5A
) (
  input  logic                noc_clk,
  input  logic                noc_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W+1:0]   in_flit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [X_W-1:0]      out_src_x,
  output logic [Y_W-1:0]      out_src_y,
  output logic                pkt_done,
  output logic                err_misroute,
  output logic                err_proto,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         err_cnt
);

  localparam int SX_HI = DATA_W - 9;
  localparam int SY_HI = SX_HI - X_W;
  localparam int DX_HI = SY_HI - Y_W;
  localparam int DY_HI = DX_HI - X_W;
  localparam logic [X_W-1:0] MY_X_V = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY_Y_V = Y_W'(MY_Y);

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  state_t              state;
  logic [DATA_W-1:0]   hold_data;
  logic                hold_full;

  logic                fire;
  logic                is_head;
  logic                is_tail;
  logic [DATA_W-1:0]   f_data;
  logic [7:0]          marker;
  logic [X_W-1:0]      f_src_x;
  logic [Y_W-1:0]      f_src_y;
  logic                dst_ok;

  // A flit can be taken whenever O is empty or is being drained this cycle,
  // so a hold-to-output move never overwrites an undelivered payload.
  assign in_ready = !(out_valid && !out_ready);
  assign fire     = in_valid && in_ready;
  assign is_head  = in_flit[DATA_W+1];
  assign is_tail  = in_flit[DATA_W];
  assign f_data   = in_flit[DATA_W-1:0];
  assign marker   = f_data[DATA_W-1 -: 8];
  assign f_src_x  = f_data[SX_HI -: X_W];
  assign f_src_y  = f_data[SY_HI -: Y_W];
  assign dst_ok   = (f_data[DX_HI -: X_W] == MY_X_V) && (f_data[DY_HI -: Y_W] == MY_Y_V);

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state        <= S_IDLE;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_src_x    <= '0;
      out_src_y    <= '0;
      pkt_done     <= 1'b0;
      err_misroute <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      pkt_done     <= 1'b0;
      err_misroute <= 1'b0;
      err_proto    <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (fire) begin
        if (is_head && is_tail) begin
          err_proto <= 1'b1;
        end else if (is_head) begin
          // A header outside IDLE aborts the current packet, then is judged
          // exactly like a header seen in IDLE. Accepting a header implies O
          // is empty next cycle, so out_src_* can be updated immediately.
          if (state != S_IDLE) err_proto <= 1'b1;
          hold_full <= 1'b0;
          if (marker != HEAD_MARK) begin
            err_proto <= 1'b1;
            state     <= S_DROP;
          end else if (!dst_ok) begin
            err_misroute <= 1'b1;
            state        <= S_DROP;
          end else begin
            out_src_x <= f_src_x;
            out_src_y <= f_src_y;
            state     <= S_BODY;
          end
        end else begin
          case (state)
            S_IDLE: err_proto <= 1'b1;
            S_BODY: begin
              if (hold_full) begin
                out_valid <= 1'b1;
                out_data  <= hold_data;
                out_last  <= is_tail;
              end
              if (is_tail) begin
                hold_full <= 1'b0;
                state     <= S_IDLE;
                if (marker == TAIL_MARK) pkt_done  <= 1'b1;
                else                     err_proto <= 1'b1;
              end else begin
                hold_data <= f_data;
                hold_full <= 1'b1;
              end
            end
            S_DROP: if (is_tail) state <= S_IDLE;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

`ifdef NOC_DEPKT_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if ((err_misroute || err_proto) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_depacketizer.sv
module tb_noc_depacketizer;

  logic         noc_clk = 1'b0;
  logic         noc_rst;
  logic         in_valid;
  logic         in_ready;
  logic [65:0]  in_flit;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic [3:0]   out_src_x;
  logic [3:0]   out_src_y;
  logic         pkt_done;
  logic         err_misroute;
  logic         err_proto;
  logic [15:0]  pkt_cnt;
  logic [15:0]  err_cnt;

`ifdef NOC_DEPKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  noc_depacketizer dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src_x(out_src_x), .out_src_y(out_src_y),
    .pkt_done(pkt_done), .err_misroute(err_misroute), .err_proto(err_proto),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  int n_vec = 0;
  int n_miscmp = 0;

  logic [64:0] outq[$];
  int n_done, n_mis, n_proto;

  // Inputs change just after posedge, so the negedge view equals what the
  // next posedge sees.
  always @(negedge noc_clk) begin
    if (!noc_rst) begin
      if (out_valid && out_ready) outq.push_back({out_last, out_data});
      if (pkt_done)     n_done++;
      if (err_misroute) n_mis++;
      if (err_proto)    n_proto++;
    end
  end

  task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] hdr(input logic [7:0] mk, input logic [3:0] sx,
                                      input logic [3:0] sy, input logic [3:0] dx,
                                      input logic [3:0] dy);
    return {2'b10, mk, sx, sy, dx, dy, 40'h0};
  endfunction

  function automatic logic [65:0] body(input logic [63:0] d);
    return {2'b00, d};
  endfunction

  function automatic logic [65:0] tail(input logic [7:0] mk);
    return {2'b01, mk, 56'h0};
  endfunction

  function automatic logic [15:0] cexp(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic send(input logic [65:0] f);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_flit  = f;
    while (!acc && n < 50) begin
      @(negedge noc_clk);
      acc = in_ready;
      @(posedge noc_clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_flit  = '0;
    if (!acc) check_val("accept_timeout", 65'(acc), 65'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge noc_clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    outq.delete();
    n_done = 0;
    n_mis = 0;
    n_proto = 0;
  endtask

  task automatic do_reset();
    noc_rst = 1'b1;
    idle(2);
    noc_rst = 1'b0;
  endtask

  initial begin
    noc_rst   = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    out_ready = 1'b1;
    clear_mon();
    @(posedge noc_clk); #1;
    do_reset();

    // reset state
    check_val("rst_out_valid", 65'(out_valid), 65'd0);
    check_val("rst_in_ready",  65'(in_ready),  65'd1);
    check_val("rst_out_data",  65'(out_data),  65'd0);
    check_val("rst_src",       65'({out_src_x, out_src_y}), 65'd0);
    check_val("rst_cnts",      65'({pkt_cnt, err_cnt}), 65'd0);

    // clean two-body packet
    clear_mon();
    send(hdr(8'hA5, 4'd3, 4'd5, 4'd0, 4'd0));
    send(body(64'h11));
    send(body(64'h22));
    send(tail(8'h5A));
    idle(4);
    check_val("t1_nout",  65'(outq.size()), 65'd2);
    if (outq.size() == 2) begin
      check_val("t1_out0", outq[0], {1'b0, 64'h11});
      check_val("t1_out1", outq[1], {1'b1, 64'h22});
    end
    check_val("t1_done",  65'(n_done), 65'd1);
    check_val("t1_proto", 65'(n_proto), 65'd0);
    check_val("t1_src",   65'({out_src_x, out_src_y}), 65'h35);
    check_val("t1_pkt_cnt", 65'(pkt_cnt), 65'(cexp(1)));

    // misrouted packet dropped, then a clean packet shows DROP returned to IDLE
    clear_mon();
    send(hdr(8'hA5, 4'd2, 4'd2, 4'd1, 4'd0));
    send(body(64'hDEAD));
    send(tail(8'h5A));
    idle(3);
    check_val("t2_nout",  65'(outq.size()), 65'd0);
    check_val("t2_mis",   65'(n_mis), 65'd1);
    check_val("t2_proto", 65'(n_proto), 65'd0);
    check_val("t2_err_cnt", 65'(err_cnt), 65'(cexp(1)));
    send(hdr(8'hA5, 4'd1, 4'd1, 4'd0, 4'd0));
    send(body(64'h55));
    send(tail(8'h5A));
    idle(3);
    check_val("t2_after_drop", outq.size() == 1 ? outq[0] : 65'h0, {1'b1, 64'h55});
    check_val("t2_pkt_cnt", 65'(pkt_cnt), 65'(cexp(2)));

    // consumer stall: O full blocks input, nothing lost, order kept
    clear_mon();
    out_ready = 1'b0;
    fork
      begin
        send(hdr(8'hA5, 4'd4, 4'd6, 4'd0, 4'd0));
        send(body(64'h11));
        send(body(64'h22));
        send(tail(8'h5A));
      end
      begin
        idle(5);
        check_val("t3_stall_in_ready",  65'(in_ready), 65'd0);
        check_val("t3_stall_out_valid", 65'(out_valid), 65'd1);
        check_val("t3_stall_out_data",  65'(out_data), 65'h11);
        out_ready = 1'b1;
      end
    join
    idle(4);
    check_val("t3_nout", 65'(outq.size()), 65'd2);
    if (outq.size() == 2) begin
      check_val("t3_out0", outq[0], {1'b0, 64'h11});
      check_val("t3_out1", outq[1], {1'b1, 64'h22});
    end
    check_val("t3_done", 65'(n_done), 65'd1);

    // header in BODY aborts the current packet
    clear_mon();
    send(hdr(8'hA5, 4'd1, 4'd2, 4'd0, 4'd0));
    send(body(64'h33));
    send(hdr(8'hA5, 4'd7, 4'd8, 4'd0, 4'd0));
    send(body(64'h44));
    send(tail(8'h5A));
    idle(4);
    check_val("t4_nout",  65'(outq.size()), 65'd1);
    check_val("t4_out",   outq.size() > 0 ? outq[0] : 65'h0, {1'b1, 64'h44});
    check_val("t4_proto", 65'(n_proto), 65'd1);
    check_val("t4_done",  65'(n_done), 65'd1);
    check_val("t4_src",   65'({out_src_x, out_src_y}), 65'h78);
    check_val("t4_cnts",  65'({pkt_cnt, err_cnt}), 65'({cexp(4), cexp(2)}));

    // bad tail marker flushes last body but reports an error
    clear_mon();
    send(hdr(8'hA5, 4'd1, 4'd1, 4'd0, 4'd0));
    send(body(64'h66));
    send(tail(8'h00));
    idle(3);
    check_val("t5_out",   outq.size() == 1 ? outq[0] : 65'h0, {1'b1, 64'h66});
    check_val("t5_proto", 65'(n_proto), 65'd1);
    check_val("t5_done",  65'(n_done), 65'd0);

    // body flit in IDLE, then header+tail combined flit
    clear_mon();
    send(body(64'h99));
    idle(2);
    check_val("t6_proto", 65'(n_proto), 65'd1);
    send({2'b11, 8'hA5, 56'h0});
    idle(2);
    check_val("t7_proto", 65'(n_proto), 65'd2);
    check_val("t7_nout",  65'(outq.size()), 65'd0);

    // zero-body packet
    clear_mon();
    send(hdr(8'hA5, 4'd2, 4'd3, 4'd0, 4'd0));
    send(tail(8'h5A));
    idle(3);
    check_val("t8_nout", 65'(outq.size()), 65'd0);
    check_val("t8_done", 65'(n_done), 65'd1);

    // bad header marker: one proto error, rest of packet silently dropped
    clear_mon();
    send(hdr(8'h00, 4'd1, 4'd1, 4'd0, 4'd0));
    send(body(64'hAB));
    send(tail(8'h5A));
    idle(3);
    check_val("t9_proto", 65'(n_proto), 65'd1);
    check_val("t9_mis",   65'(n_mis), 65'd0);
    check_val("t9_nout",  65'(outq.size()), 65'd0);
    check_val("t9_cnts",  65'({pkt_cnt, err_cnt}), 65'({cexp(5), cexp(6)}));

    // reset mid-packet with O holding a payload
    clear_mon();
    out_ready = 1'b0;
    send(hdr(8'hA5, 4'd9, 4'd9, 4'd0, 4'd0));
    send(body(64'h77));
    send(body(64'h78));
    check_val("t10_pre_out_valid", 65'(out_valid), 65'd1);
    noc_rst = 1'b1;
    idle(1);
    noc_rst = 1'b0;
    out_ready = 1'b1;
    check_val("t10_out_valid", 65'(out_valid), 65'd0);
    check_val("t10_in_ready",  65'(in_ready), 65'd1);
    check_val("t10_pulses",    65'({pkt_done, err_misroute, err_proto}), 65'd0);
    send(hdr(8'hA5, 4'd5, 4'd6, 4'd0, 4'd0));
    send(body(64'h88));
    send(tail(8'h5A));
    idle(4);
    check_val("t10_nout", 65'(outq.size()), 65'd1);
    check_val("t10_out",  outq.size() > 0 ? outq[0] : 65'h0, {1'b1, 64'h88});
    check_val("t10_done", 65'(n_done + n_mis + n_proto), 65'd1);
    check_val("t10_cnts", 65'({pkt_cnt, err_cnt}), 65'({cexp(1), cexp(0)}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
